ex_mem_stage: RTL and testbench

//  Pipeline stage directly downstream of alu_module (EX->MEM boundary). Registers the ALU result,

---
 rtl/ex_mem_pkg.sv | 24 ++
 rtl/pipe_skid_buf.sv | 87 ++++++++
 rtl/ex_mem_stage.sv | 85 ++++++++
 tb/tb_ex_mem_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline stage.
//   BR_*        : branch type codes (mirror the asm_codes.vh values used by the decoder)
//   CTL_W       : width of the {reg_wr, mem_wr, mem_rd} control bundle
//   buf_state_e : occupancy state of the 2-entry skid buffer
//   br_taken    : BEQ/BNE resolution from the ALU zero flag
package ex_mem_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;

  localparam int CTL_W = 3;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic logic br_taken(input logic [1:0] bt, input logic zero);
    return ((bt == BR_BEQ) && zero) || ((bt == BR_BNE) && !zero);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready buffer (head = main register, tail = skid register).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : drop every held entry (wins over push and pop)
//   in_valid    : push request; caller only asserts it while state != BUF_TWO
//   in_data     : payload to push
//   out_valid   : head entry valid
//   out_ready   : consumer takes the head entry
//   out_data    : head entry payload (holds while out_valid & ~out_ready)
//   state       : current buf_state_e, exported for the parent and for checkers
// Handshake: a beat transfers on a cycle where valid and ready are both high at the
// rising edge; valid never depends combinationally on ready, and data holds while stalled.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   state
);

  buf_state_e  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic        push, pop;

  assign push = in_valid & ~flush;
  assign pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (push) state_d = BUF_ONE;
        BUF_ONE: begin
          if (push && !pop)      state_d = BUF_TWO;
          else if (pop && !push) state_d = BUF_EMPTY;
        end
        BUF_TWO:   if (pop) state_d = BUF_ONE;
        default:   state_d = BUF_EMPTY;
      endcase
    end
  end

  // Outputs decoded from state only
  always_comb begin
    out_valid = (state_q != BUF_EMPTY);
    state     = state_q;
  end

  // Payload registers. Stale data left behind after pop/flush is harmless: it is
  // never presented with out_valid=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state_q)
        BUF_EMPTY: if (push) main_q <= in_data;
        BUF_ONE: begin
          if (push && pop) main_q <= in_data;   // head leaves, new beat becomes head
          else if (push)   skid_q <= in_data;   // head stalled, park beat in skid
        end
        BUF_TWO:   if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_data = main_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage behind alu_module.
// Registers ALU result, store data, dest index and control bits into a 2-entry skid
// buffer toward MEM, resolves BEQ/BNE from the zero flag and emits a one-cycle redirect.
// Ports:
//   ex_valid/ex_ready            : EX-side handshake (ex_ready is purely registered state)
//   alu_out, alu_zero, store_data, dest_reg, ctl_mem_rd, ctl_mem_wr, ctl_reg_wr,
//   br_type, br_target           : EX beat contents
//   flush                        : kill all in-flight beats and any pending redirect
//   mem_valid/mem_ready          : MEM-side handshake
//   mem_alu_out, mem_store_data, mem_dest_reg, mem_ctl : head entry ({reg_wr, mem_wr, mem_rd})
//   redirect, redirect_pc        : taken-branch pulse and target
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  input  logic [DW-1:0] store_data,
  input  logic [RW-1:0] dest_reg,
  input  logic          ctl_mem_rd,
  input  logic          ctl_mem_wr,
  input  logic          ctl_reg_wr,
  input  logic [1:0]    br_type,
  input  logic [DW-1:0] br_target,
  input  logic          flush,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_alu_out,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_dest_reg,
  output logic [2:0]    mem_ctl,
  output logic          redirect,
  output logic [DW-1:0] redirect_pc
);

  localparam int W = 2*DW + RW + CTL_W;

  logic [1:0]   buf_state;
  logic         acc, is_br, taken, push;
  logic [W-1:0] in_payload, out_payload;

  // Ready only reflects skid occupancy, so there is no path from mem_ready.
  assign ex_ready = (buf_state != BUF_TWO);

  // During the redirect cycle the EX beat is on the wrong path and is discarded.
  assign acc   = ex_valid & ex_ready & ~flush & ~redirect;
  assign is_br = (br_type != BR_NONE);
  assign taken = br_taken(br_type, alu_zero);
  // Branches do no MEM work, so they never occupy a buffer entry.
  assign push  = acc & ~is_br;

  assign in_payload = {alu_out, store_data, dest_reg, ctl_reg_wr, ctl_mem_wr, ctl_mem_rd};

  pipe_skid_buf #(.W(W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (push),
    .in_data   (in_payload),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (out_payload),
    .state     (buf_state)
  );

  assign {mem_alu_out, mem_store_data, mem_dest_reg, mem_ctl} = out_payload;

  // acc already excludes flush, so a flush also suppresses the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= acc & taken;
      if (acc && taken) redirect_pc <= br_target;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int W  = 2*DW + RW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ex_valid, ex_ready, alu_zero, ctl_mem_rd, ctl_mem_wr, ctl_reg_wr, flush;
  logic [DW-1:0] alu_out, store_data, br_target;
  logic [RW-1:0] dest_reg;
  logic [1:0]    br_type;
  logic          mem_valid, mem_ready, redirect;
  logic [DW-1:0] mem_alu_out, mem_store_data, redirect_pc;
  logic [RW-1:0] mem_dest_reg;
  logic [2:0]    mem_ctl;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .store_data(store_data), .dest_reg(dest_reg),
    .ctl_mem_rd(ctl_mem_rd), .ctl_mem_wr(ctl_mem_wr), .ctl_reg_wr(ctl_reg_wr),
    .br_type(br_type), .br_target(br_target), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_alu_out(mem_alu_out),
    .mem_store_data(mem_store_data), .mem_dest_reg(mem_dest_reg), .mem_ctl(mem_ctl),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [DW-1:0] a, input logic [DW-1:0] s,
                                      input logic [RW-1:0] d, input logic [2:0] c);
    return {a, s, d, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic z, input logic [DW-1:0] s,
                       input logic [RW-1:0] d, input logic [2:0] c, input logic [1:0] bt,
                       input logic [DW-1:0] tgt);
    ex_valid   = 1'b1;
    alu_out    = a;
    alu_zero   = z;
    store_data = s;
    dest_reg   = d;
    {ctl_reg_wr, ctl_mem_wr, ctl_mem_rd} = c;
    br_type    = bt;
    br_target  = tgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    br_type  = 2'd0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] cur_out, held_out;
  logic         held_v = 1'b0;
  assign cur_out = {mem_alu_out, mem_store_data, mem_dest_reg, mem_ctl};

  always @(negedge clk) begin
    if (held_v && mem_valid) chk("stall_hold", cur_out, held_out);
    held_v   = rst_n && mem_valid && !mem_ready;
    held_out = cur_out;
    if (rst_n && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: unexpected beat 0x%0h at %0t", cur_out, $time);
      end else begin
        chk("sb_mem_out", cur_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] alu;
    logic          zero;
    logic [DW-1:0] sd;
    logic [RW-1:0] dst;
    logic [2:0]    ctl;
    logic [1:0]    bt;
    logic [DW-1:0] tgt;
    logic          exp_mem;
    logic          exp_redir;
  } vec_t;

  vec_t vecs[8];

  initial begin
    //        alu           zero  sd            dst    ctl     bt    tgt           mem   redir
    vecs[0] = '{32'h0000_0011, 1'b0, 32'h0,         5'd3,  3'b100, 2'd0, 32'h0,         1'b1, 1'b0}; // ADD
    vecs[1] = '{32'h0000_1000, 1'b0, 32'h0,         5'd7,  3'b101, 2'd0, 32'h0,         1'b1, 1'b0}; // LW
    vecs[2] = '{32'h0000_2004, 1'b1, 32'hCAFE_BABE, 5'd0,  3'b010, 2'd0, 32'h0,         1'b1, 1'b0}; // SW
    vecs[3] = '{32'h0,         1'b1, 32'h0,         5'd0,  3'b000, 2'd0, 32'h0,         1'b1, 1'b0}; // NOP
    vecs[4] = '{32'h0,         1'b1, 32'h0,         5'd0,  3'b000, 2'd1, 32'h0000_0400, 1'b0, 1'b1}; // BEQ taken
    vecs[5] = '{32'h5,         1'b0, 32'h0,         5'd0,  3'b000, 2'd1, 32'h0000_0440, 1'b0, 1'b0}; // BEQ not
    vecs[6] = '{32'h0,         1'b1, 32'h0,         5'd0,  3'b000, 2'd2, 32'h0000_0480, 1'b0, 1'b0}; // BNE not
    vecs[7] = '{32'h9,         1'b0, 32'h0,         5'd0,  3'b000, 2'd2, 32'h0000_0800, 1'b0, 1'b1}; // BNE taken

    flush = 1'b0;
    mem_ready = 1'b1;

    // 1 Reset held with an active EX beat
    drive(32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 5'd9, 3'b111, 2'd1, 32'h0000_0900);
    repeat (3) step();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_redirect", redirect, 0);
    chk("rst_mem_out", cur_out, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table: one beat per vector with an idle cycle after it
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].alu, vecs[i].zero, vecs[i].sd, vecs[i].dst, vecs[i].ctl, vecs[i].bt, vecs[i].tgt);
      if (vecs[i].exp_mem) exp_q.push_back(pk(vecs[i].alu, vecs[i].sd, vecs[i].dst, vecs[i].ctl));
      step();
      idle();
      chk($sformatf("vec%0d_mem_valid", i), mem_valid, vecs[i].exp_mem);
      chk($sformatf("vec%0d_redirect", i), redirect, vecs[i].exp_redir);
      if (vecs[i].exp_redir) chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].tgt);
      step();
      chk($sformatf("vec%0d_redirect_end", i), redirect, 0);
      chk($sformatf("vec%0d_mem_drained", i), mem_valid, 0);
    end

    // 2 Stream of four ADDs, one per cycle
    for (int k = 1; k <= 4; k++) begin
      drive(DW'(k), 1'b0, 32'h0, 5'd1, 3'b100, 2'd0, 32'h0);
      exp_q.push_back(pk(DW'(k), 32'h0, 5'd1, 3'b100));
      step();
      chk($sformatf("stream%0d_valid", k), mem_valid, 1);
      chk($sformatf("stream%0d_alu_out", k), mem_alu_out, DW'(k));
    end
    idle();
    step();
    chk("stream_end_valid", mem_valid, 0);

    // 3 Backpressure: fill both entries, hold off a third beat, then release
    mem_ready = 1'b0;
    drive(32'hA, 1'b0, 32'h0, 5'd2, 3'b100, 2'd0, 32'h0);
    exp_q.push_back(pk(32'hA, 32'h0, 5'd2, 3'b100));
    step();
    chk("bp_ready_one", ex_ready, 1);
    drive(32'hB, 1'b0, 32'h0, 5'd2, 3'b100, 2'd0, 32'h0);
    exp_q.push_back(pk(32'hB, 32'h0, 5'd2, 3'b100));
    step();
    chk("bp_ready_full", ex_ready, 0);
    drive(32'hC, 1'b0, 32'h0, 5'd2, 3'b100, 2'd0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("bp_stall%0d_ready", s), ex_ready, 0);
      chk($sformatf("bp_stall%0d_head", s), mem_alu_out, 32'hA);
    end
    mem_ready = 1'b1;
    step();
    chk("bp_rel_head", mem_alu_out, 32'hB);
    chk("bp_rel_ready", ex_ready, 1);
    exp_q.push_back(pk(32'hC, 32'h0, 5'd2, 3'b100));
    step();
    chk("bp_c_head", mem_alu_out, 32'hC);
    idle();
    step();
    chk("bp_end_valid", mem_valid, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // 4 Taken BEQ then a younger beat during the redirect cycle
    drive(32'h0, 1'b1, 32'h0, 5'd0, 3'b000, 2'd1, 32'h0000_0400);
    step();
    chk("br_redirect", redirect, 1);
    chk("br_redirect_pc", redirect_pc, 32'h0000_0400);
    chk("br_no_mem", mem_valid, 0);
    drive(32'h55, 1'b0, 32'h0, 5'd4, 3'b100, 2'd0, 32'h0);
    step();
    chk("br_drop_redirect", redirect, 0);
    chk("br_drop_mem", mem_valid, 0);
    idle();
    step();
    chk("br_drop_mem2", mem_valid, 0);

    // 5 Flush while full, with a taken BEQ presented the same cycle
    mem_ready = 1'b0;
    drive(32'h31, 1'b0, 32'h0, 5'd5, 3'b100, 2'd0, 32'h0);
    step();
    drive(32'h32, 1'b0, 32'h0, 5'd5, 3'b100, 2'd0, 32'h0);
    step();
    chk("fl_full", ex_ready, 0);
    flush = 1'b1;
    drive(32'h0, 1'b1, 32'h0, 5'd0, 3'b000, 2'd1, 32'h0000_0500);
    step();
    flush = 1'b0;
    idle();
    chk("fl_mem_valid", mem_valid, 0);
    chk("fl_redirect", redirect, 0);
    chk("fl_ready", ex_ready, 1);
    // Flush while empty with an otherwise taken branch
    flush = 1'b1;
    drive(32'h0, 1'b1, 32'h0, 5'd0, 3'b000, 2'd1, 32'h0000_0600);
    step();
    flush = 1'b0;
    idle();
    chk("fl_br_suppress", redirect, 0);
    mem_ready = 1'b1;
    step();
    chk("fl_nothing_left", mem_valid, 0);

    // 6 Asynchronous reset pulse while full and stalled
    mem_ready = 1'b0;
    drive(32'h61, 1'b0, 32'h0, 5'd6, 3'b100, 2'd0, 32'h0);
    step();
    drive(32'h62, 1'b0, 32'h0, 5'd6, 3'b100, 2'd0, 32'h0);
    step();
    chk("ar_full", ex_ready, 0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_valid", mem_valid, 0);
    chk("ar_ready", ex_ready, 1);
    chk("ar_mem_out", cur_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    chk("ar_after_valid", mem_valid, 0);

    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: the directed sequence is bounded, this only guards against a stuck clock.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
